// File: rtl/cpu_step_controller.sv
// -----------------------------------------------------------------------------
// cpu_step_controller
//
// Sequences the single-cycle MIPS core from the raw board clock. Instead of
// feeding the processor a divided fabric clock, this block issues one-cycle
// clock-enable pulses (cpu_en) on CLK_RAW. Supported behaviours:
//   - power-on reset hold (cpu_reset held for RESET_CYCLES cycles),
//   - pause, single-step on a BUTTON_STEP rising edge,
//   - free-run with one pulse every RUN_DIV cycles (BUTTON_RUN toggles),
//   - automatic halt when pc reaches HALT_PC; any button restarts the program.
//
// Optional feature macro: CPU_STEP_BREAK_ON_MEMWRITE_EN
//   When defined, a RUN pulse issued while memwrite=1 drops back to PAUSE
//   after that pulse so each store can be inspected. When undefined,
//   memwrite is ignored.
//
// Parameters:
//   RUN_DIV      CLK_RAW cycles between pulses in RUN (2 .. 2**26)
//   RESET_CYCLES cycles cpu_reset stays high after leaving reset (>= 1)
//   HALT_PC      PC value at which execution stops
//
// Ports:
//   CLK_RAW      in   board clock; everything on its rising edge
//   RESET_N      in   asynchronous active-low reset
//   BUTTON_RUN   in   debounced level; rising edge toggles RUN / PAUSE
//   BUTTON_STEP  in   debounced level; rising edge requests one step in PAUSE
//   pc           in   current processor PC
//   memwrite     in   processor memwrite of the current instruction
//   cpu_en       out  one-cycle enable; processor advances on the edge it is high
//   cpu_reset    out  active-high synchronous reset for the processor
//   mode         out  encoded state (0 RST_HOLD,1 PAUSE,2 STEP,3 RUN,4 HALT)
//   step_count   out  pulses issued since reset (wraps)
//   halted       out  high while in HALT
// -----------------------------------------------------------------------------
module cpu_step_controller #(
  parameter int unsigned RUN_DIV      = 50000000,
  parameter int unsigned RESET_CYCLES = 4,
  parameter logic [31:0] HALT_PC      = 32'h000000D0
) (
  input  logic        CLK_RAW,
  input  logic        RESET_N,
  input  logic        BUTTON_RUN,
  input  logic        BUTTON_STEP,
  input  logic [31:0] pc,
  input  logic        memwrite,
  output logic        cpu_en,
  output logic        cpu_reset,
  output logic [2:0]  mode,
  output logic [15:0] step_count,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_PAUSE    = 3'd1,
    ST_STEP     = 3'd2,
    ST_RUN      = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  localparam int unsigned       HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [25:0]       DIV_LAST  = 26'(RUN_DIV - 1);

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [25:0]        div_q, div_d;
  logic [15:0]        step_count_q, step_count_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               halted_q, halted_d;

  logic               run_evt, step_evt;
  logic               at_halt, div_done, break_now;

  // ---------------------------------------------------------------------------
  // Button synchronizers: bit0/bit1 form the 2-flop synchronizer, bit2 is the
  // previous synchronized level used by the rising-edge detector.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_evt;
  assign btn_raw = {BUTTON_STEP, BUTTON_RUN};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [2:0] sync_q, sync_d;
      always_comb sync_d = {sync_q[1:0], btn_raw[gi]};
      always_ff @(posedge CLK_RAW or negedge RESET_N) begin
        if (!RESET_N) sync_q <= '0;
        else          sync_q <= sync_d;
      end
      assign btn_evt[gi] = sync_q[1] & ~sync_q[2];
    end
  endgenerate

  assign run_evt  = btn_evt[0];
  assign step_evt = btn_evt[1];
  assign at_halt  = (pc == HALT_PC);
  assign div_done = (div_q == DIV_LAST);

`ifdef CPU_STEP_BREAK_ON_MEMWRITE_EN
  assign break_now = memwrite;
`else
  // memwrite only matters for the store-break feature.
  logic unused_memwrite;
  assign unused_memwrite = memwrite;
  assign break_now       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_RAW or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_RST_HOLD;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Halt check wins over button events so the processor is
  // never stepped past HALT_PC.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST_HOLD: if (hold_q == HOLD_LAST) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (at_halt)       state_d = ST_HALT;
        else if (run_evt)  state_d = ST_RUN;
        else if (step_evt) state_d = ST_STEP;
      end
      ST_STEP: state_d = ST_PAUSE;
      ST_RUN: begin
        if (at_halt)                    state_d = ST_HALT;
        else if (run_evt)               state_d = ST_PAUSE;
        else if (div_done && break_now) state_d = ST_PAUSE;
      end
      ST_HALT: if (run_evt || step_evt) state_d = ST_RST_HOLD;
      default: state_d = ST_RST_HOLD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. cpu_en is decoded from registered state so an asynchronous
  // reset removes it immediately; a pause request or halt on the terminal
  // count cycle suppresses the pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_STEP: cpu_en = 1'b1;
      ST_RUN:  cpu_en = div_done && !at_halt && !run_evt;
      default: cpu_en = 1'b0;
    endcase
    cpu_reset_d = (state_d == ST_RST_HOLD);
    halted_d    = (state_d == ST_HALT);
  end

  // ---------------------------------------------------------------------------
  // Counters. Hold and divider counters only advance while staying in their
  // own state, so they are always zero on entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_d       = '0;
    div_d        = '0;
    step_count_d = step_count_q;
    if (state_q == ST_RST_HOLD && state_d == ST_RST_HOLD) hold_d = hold_q + 1'b1;
    if (state_q == ST_RUN && state_d == ST_RUN && !div_done) div_d = div_q + 26'd1;
    if (cpu_en) step_count_d = step_count_q + 16'd1;
  end

  always_ff @(posedge CLK_RAW or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_q       <= '0;
      div_q        <= '0;
      step_count_q <= '0;
      cpu_reset_q  <= 1'b1;
      halted_q     <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      div_q        <= div_d;
      step_count_q <= step_count_d;
      cpu_reset_q  <= cpu_reset_d;
      halted_q     <= halted_d;
    end
  end

  assign mode       = state_q;
  assign cpu_reset  = cpu_reset_q;
  assign halted     = halted_q;
  assign step_count = step_count_q;

endmodule
